// File: rtl/spi_peripheral_target.sv
// SPI mode-0 target that decodes {WnR, address, data_len} headers and bridges
// the following data words onto a simple register-file port.
module spi_peripheral_target #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int LEN_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  axi_clk,
    input  logic                  reset_b,
    input  logic                  spi_clk,
    input  logic                  cs_b,
    input  logic                  pico,
    output logic                  poci,
    output logic                  poci_oe,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int HDR_W = 1 + ADDR_WIDTH + LEN_WIDTH;
    localparam int MAXB  = (HDR_W > DATA_WIDTH) ? HDR_W : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAXB + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, pico_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, pico_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    logic [CNT_W-1:0]      bit_cnt;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [HDR_W-2:0]      hdr_sr;
    logic [DATA_WIDTH-2:0] data_sr;
    logic [DATA_WIDTH-1:0] sh_sr;
    logic [DATA_WIDTH-1:0] pf_data;
    logic                  rd_pending, load_first, shift_ok;

    logic [HDR_W-1:0]      hdr_full;
    logic                  hdr_wnr;
    logic [ADDR_WIDTH-1:0] hdr_addr;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic                  hdr_last, word_end, word_last;

    // All three SPI inputs share one synchronizer depth so their relative timing is kept.
    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            pico_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_b};
            pico_sync <= {pico_sync[SYNC_STAGES-2:0], pico};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign pico_s    = pico_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    assign hdr_full  = {hdr_sr, pico_s};
    assign hdr_wnr   = hdr_full[HDR_W-1];
    assign hdr_addr  = hdr_full[LEN_WIDTH +: ADDR_WIDTH];
    assign hdr_len   = hdr_full[LEN_WIDTH-1:0];
    assign hdr_last  = (state == ST_HEADER) && sclk_rise && (bit_cnt == CNT_W'(HDR_W - 1));
    assign word_end  = sclk_rise && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign word_last = word_end && (word_cnt == LEN_WIDTH'(1));

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != ST_IDLE);
        poci_oe    = (state == ST_READ);
        poci       = poci_oe & sh_sr[DATA_WIDTH-1];
        frame_done = 1'b0;
        frame_err  = 1'b0;
        if (state == ST_IDLE) begin
            if (cs_fall) begin
                state_nxt = ST_HEADER;
            end
        end else if (cs_s) begin
            state_nxt = ST_IDLE;
            if (state == ST_DRAIN) begin
                frame_done = 1'b1;
            end else begin
                frame_err = 1'b1;
            end
        end else begin
            case (state)
                ST_HEADER: begin
                    if (hdr_last) begin
                        if (hdr_len == '0) begin
                            state_nxt = ST_DRAIN;
                        end else if (hdr_wnr) begin
                            state_nxt = ST_WRITE;
                        end else begin
                            state_nxt = ST_READ;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (word_last) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Read words are prefetched two bits early so the next MSB is ready on the word-boundary fall.
    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            bit_cnt    <= '0;
            word_cnt   <= '0;
            hdr_sr     <= '0;
            data_sr    <= '0;
            sh_sr      <= '0;
            pf_data    <= '0;
            rd_pending <= 1'b0;
            load_first <= 1'b0;
            shift_ok   <= 1'b0;
            reg_addr   <= '0;
            reg_wr_en  <= 1'b0;
            reg_wdata  <= '0;
            reg_rd_en  <= 1'b0;
        end else begin
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            rd_pending <= reg_rd_en;
            if (reg_wr_en) begin
                reg_addr <= reg_addr + ADDR_WIDTH'(1);
            end
            if (rd_pending) begin
                pf_data <= reg_rdata;
                if (load_first) begin
                    sh_sr      <= reg_rdata;
                    load_first <= 1'b0;
                end
            end
            if (state == ST_IDLE || cs_s) begin
                bit_cnt    <= '0;
                shift_ok   <= 1'b0;
                load_first <= 1'b0;
                sh_sr      <= '0;
            end else begin
                case (state)
                    ST_HEADER: begin
                        if (sclk_rise) begin
                            hdr_sr  <= {hdr_sr[HDR_W-3:0], pico_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (hdr_last) begin
                                bit_cnt  <= '0;
                                word_cnt <= hdr_len;
                                reg_addr <= hdr_addr;
                                if (!hdr_wnr && hdr_len != '0) begin
                                    reg_rd_en  <= 1'b1;
                                    load_first <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (sclk_rise) begin
                            data_sr <= {data_sr[DATA_WIDTH-3:0], pico_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (word_end) begin
                                bit_cnt   <= '0;
                                word_cnt  <= word_cnt - LEN_WIDTH'(1);
                                reg_wr_en <= 1'b1;
                                reg_wdata <= {data_sr, pico_s};
                            end
                        end
                    end
                    ST_READ: begin
                        if (sclk_rise) begin
                            shift_ok <= 1'b1;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 2) && word_cnt > LEN_WIDTH'(1)) begin
                                reg_rd_en <= 1'b1;
                                reg_addr  <= reg_addr + ADDR_WIDTH'(1);
                            end
                            if (word_end) begin
                                bit_cnt  <= '0;
                                word_cnt <= word_cnt - LEN_WIDTH'(1);
                            end
                        end else if (sclk_fall && shift_ok) begin
                            shift_ok <= 1'b0;
                            if (bit_cnt == '0) begin
                                sh_sr <= pf_data;
                            end else begin
                                sh_sr <= {sh_sr[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral_target.sv
// Scoreboard bench for spi_peripheral_target: acts as SPI controller and as a
// register file whose read data is addr*3.
module tb_spi_peripheral_target;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int LW   = 8;
    localparam int HALF = 80;

    logic          axi_clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          spi_clk = 1'b0;
    logic          cs_b    = 1'b1;
    logic          pico    = 1'b0;
    logic          poci, poci_oe, reg_wr_en, reg_rd_en, busy, frame_done, frame_err;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata = 32'hA5A5_A5A5;

    int errors   = 0;
    int checks   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [AW-1:0] exp_wr_addr_q[$];
    logic [DW-1:0] exp_wr_data_q[$];
    logic [AW-1:0] exp_rd_addr_q[$];
    logic [DW-1:0] exp_word_q[$];

    logic          rd_prev = 1'b0;
    logic [AW-1:0] rd_addr_prev = '0;
    logic [AW-1:0] mon_ea;
    logic [DW-1:0] mon_ed;

    spi_peripheral_target dut (
        .axi_clk    (axi_clk),
        .reset_b    (reset_b),
        .spi_clk    (spi_clk),
        .cs_b       (cs_b),
        .pico       (pico),
        .poci       (poci),
        .poci_oe    (poci_oe),
        .reg_addr   (reg_addr),
        .reg_wr_en  (reg_wr_en),
        .reg_wdata  (reg_wdata),
        .reg_rd_en  (reg_rd_en),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 axi_clk = ~axi_clk;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return DW'(a) * 32'd3;
    endfunction

    // Register-file model and strobe scoreboard, sampled mid-cycle.
    always @(negedge axi_clk) begin
        reg_rdata    = rd_prev ? model_rd(rd_addr_prev) : 32'hA5A5_A5A5;
        rd_prev      = reg_rd_en;
        rd_addr_prev = reg_addr;
        if (reg_wr_en) begin
            wr_cnt++;
            checks++;
            if (exp_wr_addr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write addr=%h data=%h required no write", reg_addr, reg_wdata);
            end else begin
                mon_ea = exp_wr_addr_q.pop_front();
                mon_ed = exp_wr_data_q.pop_front();
                if (reg_addr !== mon_ea || reg_wdata !== mon_ed) begin
                    errors++;
                    $display("[TB] FAIL write_strobe got addr=%h data=%h required addr=%h data=%h",
                             reg_addr, reg_wdata, mon_ea, mon_ed);
                end
            end
        end
        if (reg_rd_en) begin
            rd_cnt++;
            checks++;
            if (exp_rd_addr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_read addr=%h required no read", reg_addr);
            end else begin
                mon_ea = exp_rd_addr_q.pop_front();
                if (reg_addr !== mon_ea) begin
                    errors++;
                    $display("[TB] FAIL read_strobe got addr=%h required addr=%h", reg_addr, mon_ea);
                end
            end
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (frame_done || frame_err) begin
            checks++;
            if (frame_done && frame_err) begin
                errors++;
                $display("[TB] FAIL done_err_exclusive got done=1 err=1 required only one");
            end
        end
    end

    task automatic spi_bit(input logic b, output logic s);
        pico = b;
        #HALF;
        s = poci;
        spi_clk = 1'b1;
        #HALF;
        spi_clk = 1'b0;
    endtask

    task automatic send_header(input logic wnr, input logic [AW-1:0] a, input logic [LW-1:0] len);
        logic [18:0] h;
        logic        s;
        h = {wnr, a, len};
        for (int i = 18; i >= 0; i--) spi_bit(h[i], s);
    endtask

    task automatic send_bits(input logic [DW-1:0] d, input int n, output logic [DW-1:0] got);
        logic s;
        got = '0;
        for (int i = 0; i < n; i++) begin
            spi_bit(d[DW-1-i], s);
            got = {got[DW-2:0], s};
        end
    endtask

    task automatic cs_end();
        #HALF;
        cs_b = 1'b1;
        pico = 1'b0;
        #(HALF * 2);
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (3) @(posedge axi_clk);
        #1;
        checks++;
        if ({poci, poci_oe, reg_wr_en, reg_rd_en, busy, frame_done, frame_err} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b required 0000000",
                     {poci, poci_oe, reg_wr_en, reg_rd_en, busy, frame_done, frame_err});
        end
        checks++;
        if (reg_addr !== '0 || reg_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_buses got addr=%h wdata=%h required 0", reg_addr, reg_wdata);
        end
        @(negedge axi_clk);
        reset_b = 1'b1;
        repeat (5) @(negedge axi_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset busy got %b required 0", busy);
        end
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input string name);
        int            w0, dn0, er0;
        logic [DW-1:0] got;
        w0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
        exp_wr_addr_q.push_back(a);
        exp_wr_data_q.push_back(d0);
        exp_wr_addr_q.push_back(a + AW'(1));
        exp_wr_data_q.push_back(d1);
        cs_b = 1'b0;
        send_header(1'b1, a, 8'd2);
        send_bits(d0, 32, got);
        send_bits(d1, 32, got);
        cs_end();
        checks++;
        if (wr_cnt - w0 != 2 || exp_wr_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_writes got %0d left=%0d required 2 left=0", name, wr_cnt - w0, exp_wr_addr_q.size());
        end
        checks++;
        if (done_cnt - dn0 != 1 || err_cnt - er0 != 0) begin
            errors++;
            $display("[TB] FAIL %s_pulses got done=%0d err=%0d required done=1 err=0", name, done_cnt - dn0, err_cnt - er0);
        end
    endtask

    task automatic test_write();
        run_write(10'h005, 32'hDEAD_BEEF, 32'h1234_5678, "write");
    endtask

    task automatic test_wrap();
        run_write(10'h3FF, $urandom, $urandom, "wrap");
    endtask

    task automatic test_read();
        int            r0, dn0, er0;
        logic [DW-1:0] got, exp;
        r0 = rd_cnt; dn0 = done_cnt; er0 = err_cnt;
        for (int w = 0; w < 3; w++) begin
            exp_rd_addr_q.push_back(10'h010 + AW'(w));
            exp_word_q.push_back(model_rd(10'h010 + AW'(w)));
        end
        cs_b = 1'b0;
        send_header(1'b0, 10'h010, 8'd3);
        checks++;
        if (poci_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_oe got %b required 1", poci_oe);
        end
        for (int w = 0; w < 3; w++) begin
            send_bits($urandom, 32, got);
            exp = exp_word_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL read_word%0d got %h required %h", w, got, exp);
            end
        end
        cs_end();
        checks++;
        if (rd_cnt - r0 != 3 || exp_rd_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL read_strobes got %0d left=%0d required 3 left=0", rd_cnt - r0, exp_rd_addr_q.size());
        end
        checks++;
        if (done_cnt - dn0 != 1 || err_cnt - er0 != 0 || poci_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_end got done=%0d err=%0d oe=%b required done=1 err=0 oe=0",
                     done_cnt - dn0, err_cnt - er0, poci_oe);
        end
    endtask

    task automatic test_abort();
        int            w0, dn0, er0;
        logic [DW-1:0] d0, got;
        w0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
        d0 = $urandom;
        exp_wr_addr_q.push_back(10'h040);
        exp_wr_data_q.push_back(d0);
        cs_b = 1'b0;
        send_header(1'b1, 10'h040, 8'd2);
        send_bits(d0, 32, got);
        send_bits($urandom, 8, got);
        cs_b = 1'b1;
        #(HALF * 2);
        checks++;
        if (wr_cnt - w0 != 1 || exp_wr_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL abort_writes got %0d required 1", wr_cnt - w0);
        end
        checks++;
        if (err_cnt - er0 != 1 || done_cnt - dn0 != 0) begin
            errors++;
            $display("[TB] FAIL abort_pulses got err=%0d done=%0d required err=1 done=0", err_cnt - er0, done_cnt - dn0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_busy got %b required 0", busy);
        end
    endtask

    task automatic test_len_zero();
        int   w0, r0, dn0, er0;
        logic s, any_poci, any_oe;
        w0 = wr_cnt; r0 = rd_cnt; dn0 = done_cnt; er0 = err_cnt;
        any_poci = 1'b0;
        any_oe   = 1'b0;
        cs_b = 1'b0;
        send_header(1'b0, 10'h055, 8'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_busy got %b required 1", busy);
        end
        for (int i = 0; i < 16; i++) begin
            spi_bit(1'($urandom), s);
            any_poci |= s;
            any_oe   |= poci_oe;
        end
        checks++;
        if (any_poci !== 1'b0 || any_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_poci got poci=%b oe=%b required 0 0", any_poci, any_oe);
        end
        cs_end();
        checks++;
        if (wr_cnt != w0 || rd_cnt != r0) begin
            errors++;
            $display("[TB] FAIL drain_strobes got wr=%0d rd=%0d required 0 0", wr_cnt - w0, rd_cnt - r0);
        end
        checks++;
        if (done_cnt - dn0 != 1 || err_cnt - er0 != 0) begin
            errors++;
            $display("[TB] FAIL drain_pulses got done=%0d err=%0d required done=1 err=0", done_cnt - dn0, err_cnt - er0);
        end
    endtask

    task automatic test_reset_mid();
        int            w0, dn0, er0;
        logic [DW-1:0] got, exp, d0;
        exp_rd_addr_q.push_back(10'h020);
        exp_rd_addr_q.push_back(10'h021);
        exp_word_q.push_back(model_rd(10'h020));
        cs_b = 1'b0;
        send_header(1'b0, 10'h020, 8'd3);
        send_bits('0, 32, got);
        exp = exp_word_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL rstmid_word0 got %h required %h", got, exp);
        end
        send_bits('0, 10, got);
        #(HALF / 2);
        reset_b = 1'b0;
        #1;
        checks++;
        if ({poci, poci_oe, reg_wr_en, reg_rd_en, busy, frame_done, frame_err} !== 7'b0 ||
            reg_addr !== '0 || reg_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs got flags=%b addr=%h wdata=%h required all 0",
                     {poci, poci_oe, reg_wr_en, reg_rd_en, busy, frame_done, frame_err}, reg_addr, reg_wdata);
        end
        checks++;
        if (exp_rd_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_reads got left=%0d required left=0", exp_rd_addr_q.size());
        end
        cs_b = 1'b1;
        #50;
        @(negedge axi_clk);
        reset_b = 1'b1;
        repeat (5) @(negedge axi_clk);
        w0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
        d0 = $urandom;
        exp_wr_addr_q.push_back(10'h100);
        exp_wr_data_q.push_back(d0);
        cs_b = 1'b0;
        send_header(1'b1, 10'h100, 8'd1);
        send_bits(d0, 32, got);
        cs_end();
        checks++;
        if (wr_cnt - w0 != 1 || done_cnt - dn0 != 1 || err_cnt - er0 != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_recover got wr=%0d done=%0d err=%0d required 1 1 0",
                     wr_cnt - w0, done_cnt - dn0, err_cnt - er0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_len_zero();
        test_reset_mid();
        repeat (10) @(negedge axi_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
